// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline registers it drives.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b01,
        FLUSH = 2'b10
    } hz_state_e;

    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam logic [4:0]  REG_X0   = 5'd0;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter with synchronous active-low reset and a clear that beats increment.
module sat_counter
    import hazard_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-branch flush control for the IF/ID and ID/EX pipeline registers.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned BR_FLUSH_CYCLES = 1,
    parameter int unsigned COUNT_W         = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         rs1_id,
    input  logic [4:0]         rs2_id,
    input  logic               uses_rs1_id,
    input  logic               uses_rs2_id,
    input  logic [4:0]         rd_ex,
    input  logic               MemRead_ex,
    input  logic               branch_ex,
    input  logic               branch_taken_ex,
    input  logic               counters_clear,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               flushing,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam logic [3:0] DCNT_LOAD = 4'(BR_FLUSH_CYCLES - 1);

    hz_state_e  state_q;
    logic [3:0] dcnt_q;
    logic       hazard_lu;
    logic       br_taken;
    logic       stall_inc;
    logic       flush_inc;

    assign hazard_lu = MemRead_ex && (rd_ex != REG_X0) &&
                       ((uses_rs1_id && (rd_ex == rs1_id)) ||
                        (uses_rs2_id && (rd_ex == rs2_id)));
    assign br_taken  = branch_ex && branch_taken_ex;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            dcnt_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (br_taken && (BR_FLUSH_CYCLES > 1)) begin
                        state_q <= FLUSH;
                        dcnt_q  <= DCNT_LOAD;
                    end
                end
                FLUSH: begin
                    dcnt_q <= dcnt_q - 4'd1;
                    // <=1 also guards against a corrupted zero count
                    if (dcnt_q <= 4'd1) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                    dcnt_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    // Wrong-path ID instruction makes a coincident load-use irrelevant
                    if (br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (hazard_lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign flushing = reset && (state_q == FLUSH);

    sat_counter #(.W(COUNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (counters_clear),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(COUNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .clear (counters_clear),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit across three parameterisations sharing one stimulus bus.
module tb_hazard_control_unit;

    logic       clock;
    logic       reset;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       uses_rs1_id, uses_rs2_id, MemRead_ex;
    logic       branch_ex, branch_taken_ex, counters_clear;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_flushing;
    logic [3:0]  a_stall_count, a_flush_count;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_flushing;
    logic [31:0] b_stall_count, b_flush_count;
    logic        c_pc_write, c_if_id_write, c_if_id_flush, c_id_ex_flush, c_flushing;
    logic [31:0] c_stall_count, c_flush_count;

    int checks   = 0;
    int failures = 0;

    hazard_control_unit #(.BR_FLUSH_CYCLES(1), .COUNT_W(4)) dut_a (
        .clock(clock), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex), .branch_ex(branch_ex), .branch_taken_ex(branch_taken_ex),
        .counters_clear(counters_clear), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .flushing(a_flushing),
        .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_control_unit #(.BR_FLUSH_CYCLES(3), .COUNT_W(32)) dut_b (
        .clock(clock), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex), .branch_ex(branch_ex), .branch_taken_ex(branch_taken_ex),
        .counters_clear(counters_clear), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .flushing(b_flushing),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    hazard_control_unit #(.BR_FLUSH_CYCLES(4), .COUNT_W(32)) dut_c (
        .clock(clock), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
        .MemRead_ex(MemRead_ex), .branch_ex(branch_ex), .branch_taken_ex(branch_taken_ex),
        .counters_clear(counters_clear), .pc_write(c_pc_write), .if_id_write(c_if_id_write),
        .if_id_flush(c_if_id_flush), .id_ex_flush(c_id_ex_flush), .flushing(c_flushing),
        .stall_count(c_stall_count), .flush_count(c_flush_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; MemRead_ex = 1'b0;
        branch_ex = 1'b0; branch_taken_ex = 1'b0; counters_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                            input logic u1, input logic u2);
        MemRead_ex = 1'b1; rd_ex = rd; rs1_id = r1; rs2_id = r2;
        uses_rs1_id = u1; uses_rs2_id = u2;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #2;
        check_eq("rst_pc_write",    32'(a_pc_write),    32'd0);
        check_eq("rst_if_id_write", 32'(a_if_id_write), 32'd0);
        check_eq("rst_if_id_flush", 32'(a_if_id_flush), 32'd1);
        check_eq("rst_id_ex_flush", 32'(a_id_ex_flush), 32'd1);
        check_eq("rst_flushing",    32'(a_flushing),    32'd0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check_eq("post_rst_pc_write",    32'(a_pc_write),    32'd1);
        check_eq("post_rst_if_id_write", 32'(a_if_id_write), 32'd1);
        check_eq("post_rst_flushes",     32'({a_if_id_flush, a_id_ex_flush}), 32'd0);
        check_eq("post_rst_stall_cnt",   32'(a_stall_count), 32'd0);
        check_eq("post_rst_flush_cnt",   32'(a_flush_count), 32'd0);

        // Load-use on rs1
        load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        check_eq("lu_pc_write",    32'(a_pc_write),    32'd0);
        check_eq("lu_if_id_write", 32'(a_if_id_write), 32'd0);
        check_eq("lu_id_ex_flush", 32'(a_id_ex_flush), 32'd1);
        check_eq("lu_if_id_flush", 32'(a_if_id_flush), 32'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("lu_stall_cnt", 32'(a_stall_count), 32'd1);
        check_eq("lu_after_pc",  32'(a_pc_write),    32'd1);

        // x0 destination never stalls
        load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        check_eq("x0_pc_write", 32'(a_pc_write), 32'd1);
        tick();
        idle_inputs();
        #1;
        check_eq("x0_stall_cnt", 32'(a_stall_count), 32'd1);

        // Register match but operand not read
        load_use(5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
        #1;
        check_eq("unused_pc_write",    32'(a_pc_write),    32'd1);
        check_eq("unused_id_ex_flush", 32'(a_id_ex_flush), 32'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("unused_stall_cnt", 32'(a_stall_count), 32'd1);

        // Load-use on rs2
        load_use(5'd7, 5'd1, 5'd7, 1'b1, 1'b1);
        #1;
        check_eq("lu2_pc_write", 32'(a_pc_write), 32'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("lu2_stall_cnt", 32'(a_stall_count), 32'd2);

        // Taken branch together with rs2 load-use
        do_reset();
        load_use(5'd9, 5'd0, 5'd9, 1'b0, 1'b1);
        branch_ex = 1'b1; branch_taken_ex = 1'b1;
        #1;
        check_eq("sim_if_id_flush", 32'(a_if_id_flush), 32'd1);
        check_eq("sim_id_ex_flush", 32'(a_id_ex_flush), 32'd1);
        check_eq("sim_pc_write",    32'(a_pc_write),    32'd1);
        check_eq("sim_if_id_write", 32'(a_if_id_write), 32'd1);
        tick();
        idle_inputs();
        #1;
        check_eq("sim_flush_cnt",  32'(a_flush_count), 32'd1);
        check_eq("sim_stall_cnt",  32'(a_stall_count), 32'd0);
        check_eq("sim_flushing",   32'(a_flushing),    32'd0);
        check_eq("sim_after_fl",   32'(a_if_id_flush), 32'd0);

        // Not-taken branch is harmless
        branch_ex = 1'b1; branch_taken_ex = 1'b0;
        #1;
        check_eq("nt_if_id_flush", 32'(a_if_id_flush), 32'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("nt_flush_cnt", 32'(a_flush_count), 32'd1);

        // Three-cycle flush; repeated branch and load-use inside FLUSH are ignored
        do_reset();
        branch_ex = 1'b1; branch_taken_ex = 1'b1;
        #1;
        check_eq("mc1_if_id_flush", 32'(b_if_id_flush), 32'd1);
        check_eq("mc1_id_ex_flush", 32'(b_id_ex_flush), 32'd1);
        check_eq("mc1_flushing",    32'(b_flushing),    32'd0);
        tick();
        #1;
        check_eq("mc2_flushes",  32'({b_if_id_flush, b_id_ex_flush}), 32'd3);
        check_eq("mc2_flushing", 32'(b_flushing), 32'd1);
        tick();
        idle_inputs();
        load_use(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
        #1;
        check_eq("mc3_flushes",  32'({b_if_id_flush, b_id_ex_flush}), 32'd3);
        check_eq("mc3_flushing", 32'(b_flushing), 32'd1);
        check_eq("mc3_pc_write", 32'(b_pc_write), 32'd1);
        tick();
        idle_inputs();
        #1;
        check_eq("mc4_flushes",   32'({b_if_id_flush, b_id_ex_flush}), 32'd0);
        check_eq("mc4_flushing",  32'(b_flushing),    32'd0);
        check_eq("mc4_flush_cnt", b_flush_count,      32'd1);
        check_eq("mc4_stall_cnt", b_stall_count,      32'd0);

        // Saturation at 4 bits, then clear beats a coincident stall
        do_reset();
        load_use(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
        repeat (20) tick();
        check_eq("sat_stall_cnt", 32'(a_stall_count), 32'd15);
        counters_clear = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_eq("clr_stall_cnt", 32'(a_stall_count), 32'd0);

        // Reset during the second cycle of a four-cycle flush
        do_reset();
        branch_ex = 1'b1; branch_taken_ex = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_eq("rmf_flushing_pre",  32'(c_flushing),    32'd1);
        check_eq("rmf_flush_cnt_pre", c_flush_count,      32'd1);
        reset = 1'b0;
        #1;
        check_eq("rmf_rst_pc_write", 32'(c_pc_write),    32'd0);
        check_eq("rmf_rst_flushing", 32'(c_flushing),    32'd0);
        check_eq("rmf_rst_if_flush", 32'(c_if_id_flush), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check_eq("rmf_rel_flushes",   32'({c_if_id_flush, c_id_ex_flush}), 32'd0);
        check_eq("rmf_rel_flushing",  32'(c_flushing),    32'd0);
        check_eq("rmf_rel_pc_write",  32'(c_pc_write),    32'd1);
        check_eq("rmf_rel_flush_cnt", c_flush_count,      32'd0);
        tick();
        check_eq("rmf_late_flushes",  32'({c_if_id_flush, c_id_ex_flush}), 32'd0);
        check_eq("rmf_late_flushing", 32'(c_flushing),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
